// File: rtl/relnet_pktgen_pkg.sv
// relnet_pktgen_pkg
// Shared types and constants for the relnet UDP/GBN packet generator:
// GBN packet types, FSM state encoding, UDP header layout, GBN data-beat
// layout and the constant-fill payload patterns.
package relnet_pktgen_pkg;

  typedef enum logic [7:0] {
    PKT_ACK  = 8'd1,
    PKT_NACK = 8'd2,
    PKT_DATA = 8'd3
  } pkt_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_HDR,
    ST_GBN,
    ST_PLD
  } state_t;

  // UDP header word: {length, dest_port, src_port, dest_ip, src_ip}
  localparam int UDP_HDR_W   = 112;
  localparam int UDP_LEN_LSB = 96;
  localparam int UDP_LEN_W   = 16;

  // GBN data beat: {session_id, seq, pkt_type}
  localparam int GBN_TYPE_LSB = 0;
  localparam int GBN_SEQ_LSB  = 8;
  localparam int GBN_SID_LSB  = 40;

  localparam logic [63:0] FILL_BODY = 64'h0f0f_0f0f_0f0f_0f0f;
  localparam logic [63:0] FILL_LAST = 64'h0101_0101_0101_0101;

  function automatic logic [63:0] gbn_beat(input logic [23:0] sid, input logic [31:0] seq);
    logic [63:0] b;
    b = '0;
    b[GBN_TYPE_LSB +: 8]  = PKT_DATA;
    b[GBN_SEQ_LSB  +: 32] = seq;
    b[GBN_SID_LSB  +: 24] = sid;
    return b;
  endfunction

endpackage

// File: rtl/relnet_rr_arb.sv
// relnet_rr_arb
// Round-robin arbiter. Search starts one past the last accepted grant, so
// after reset (pointer = N-1) requester 0 has highest priority.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req [N]      : request vector
//   accept       : strobe; moves the pointer to the current grant
//   grant [N]    : one-hot grant (combinational)
//   grant_valid  : at least one request is granted
module relnet_rr_arb #(
  parameter int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  logic [IW-1:0] last;

  // Two passes with constant indices: first the requesters above the
  // pointer, then wrap around to those at or below it.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!grant_valid && req[j] && (j > int'(last))) begin
        grant[j]    = 1'b1;
        grant_valid = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!grant_valid && req[j] && (j <= int'(last))) begin
        grant[j]    = 1'b1;
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= IW'(N - 1);
    end else if (accept) begin
      for (int j = 0; j < N; j++) begin
        if (grant[j]) last <= IW'(j);
      end
    end
  end

endmodule

// File: rtl/relnet_pktgen.sv
// relnet_pktgen
// Multi-session UDP/GBN traffic generator. Each packet is one UDP header
// on the header channel followed by a GBN data beat and cfg_beats payload
// beats on the payload channel. Sessions are served round-robin.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_*                    : per-session config write (ignored while busy)
//   start / busy / done      : run control
//   m_udp_hdr_*              : UDP header channel (valid/ready)
//   m_udp_payload_axis_*     : 64-bit payload stream
//
// state | meaning
// IDLE  | waiting for start; remaining counts latched on start
// ARB   | pick next session with packets left, or finish with done
// HDR   | UDP header valid, waiting for hdr_ready
// GBN   | GBN data header beat valid
// PLD   | payload beats valid, beats_left counts down to the last
module relnet_pktgen
  import relnet_pktgen_pkg::*;
#(
  parameter int NUM_SESSIONS = 4,
  parameter int SEQ_WIDTH    = 32,
  parameter int BEAT_WIDTH   = 8,
  parameter int CNT_WIDTH    = 16,
  localparam int IDX_W       = $clog2(NUM_SESSIONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_wr,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [UDP_HDR_W-1:0] cfg_hdr,
  input  logic [23:0]          cfg_session_id,
  input  logic [SEQ_WIDTH-1:0] cfg_seq_init,
  input  logic [CNT_WIDTH-1:0] cfg_pkts,
  input  logic [BEAT_WIDTH-1:0] cfg_beats,
  input  logic                 cfg_mode,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [UDP_HDR_W-1:0] m_udp_hdr_data,
  output logic                 m_udp_hdr_valid,
  input  logic                 m_udp_hdr_ready,
  output logic [63:0]          m_udp_payload_axis_tdata,
  output logic [7:0]           m_udp_payload_axis_tkeep,
  output logic                 m_udp_payload_axis_tvalid,
  input  logic                 m_udp_payload_axis_tready,
  output logic                 m_udp_payload_axis_tlast,
  output logic                 m_udp_payload_axis_tuser
);

  localparam int LEN_CALC_W = BEAT_WIDTH + 4;

  logic [UDP_LEN_LSB-1:0] hdr_mem   [NUM_SESSIONS];
  logic [23:0]            sid_mem   [NUM_SESSIONS];
  logic [SEQ_WIDTH-1:0]   seq_mem   [NUM_SESSIONS];
  logic [CNT_WIDTH-1:0]   pkts_mem  [NUM_SESSIONS];
  logic [CNT_WIDTH-1:0]   remaining [NUM_SESSIONS];
  logic [BEAT_WIDTH-1:0]  beats_mem [NUM_SESSIONS];
  logic [NUM_SESSIONS-1:0] mode_mem;

  state_t                 state;
  logic [IDX_W-1:0]       cur;
  logic [BEAT_WIDTH-1:0]  beats_left;

  logic [NUM_SESSIONS-1:0] req, grant;
  logic                   grant_valid, arb_accept, pkt_close;
  logic [IDX_W-1:0]       grant_idx;
  logic [LEN_CALC_W-1:0]  len_full;
  logic [UDP_LEN_W-1:0]   grant_len;
  logic [31:0]            seq_ext;
  logic [BEAT_WIDTH-1:0]  cur_beats, next_left, next_idx;
  logic                   unused_len;

  assign m_udp_payload_axis_tkeep = 8'hff;
  assign m_udp_payload_axis_tuser = 1'b0;
  // Length field of the configured header is replaced on output.
  assign unused_len = &cfg_hdr[UDP_HDR_W-1:UDP_LEN_LSB];

  always_comb begin
    for (int i = 0; i < NUM_SESSIONS; i++) req[i] = (remaining[i] != '0);
    grant_idx = '0;
    for (int i = 0; i < NUM_SESSIONS; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  assign arb_accept = (state == ST_ARB) && grant_valid;

  relnet_rr_arb #(.N(NUM_SESSIONS)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .accept      (arb_accept),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Wire length = 8 bytes per beat including the GBN beat, truncated to 16 bits.
  assign len_full  = (LEN_CALC_W'(beats_mem[grant_idx]) + LEN_CALC_W'(1)) << 3;
  assign grant_len = UDP_LEN_W'(len_full);

  always_comb begin
    seq_ext                 = '0;
    seq_ext[SEQ_WIDTH-1:0]  = seq_mem[cur];
  end

  assign cur_beats = beats_mem[cur];
  assign next_left = beats_left - BEAT_WIDTH'(1);
  assign next_idx  = cur_beats - next_left;
  assign pkt_close = ((state == ST_GBN) || (state == ST_PLD)) &&
                     m_udp_payload_axis_tready && m_udp_payload_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= ST_IDLE;
      cur                       <= '0;
      beats_left                <= '0;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      m_udp_hdr_data            <= '0;
      m_udp_hdr_valid           <= 1'b0;
      m_udp_payload_axis_tdata  <= '0;
      m_udp_payload_axis_tvalid <= 1'b0;
      m_udp_payload_axis_tlast  <= 1'b0;
      mode_mem                  <= '0;
      for (int i = 0; i < NUM_SESSIONS; i++) begin
        hdr_mem[i]   <= '0;
        sid_mem[i]   <= '0;
        seq_mem[i]   <= '0;
        pkts_mem[i]  <= '0;
        remaining[i] <= '0;
        beats_mem[i] <= '0;
      end
    end else begin
      done <= 1'b0;

      if (cfg_wr && !busy) begin
        hdr_mem[cfg_idx]   <= cfg_hdr[UDP_LEN_LSB-1:0];
        sid_mem[cfg_idx]   <= cfg_session_id;
        seq_mem[cfg_idx]   <= cfg_seq_init;
        pkts_mem[cfg_idx]  <= cfg_pkts;
        beats_mem[cfg_idx] <= cfg_beats;
        mode_mem[cfg_idx]  <= cfg_mode;
      end

      case (state)
        ST_IDLE: begin
          // done still high means busy fell this cycle; such a start is dropped
          if (start && !done) begin
            for (int i = 0; i < NUM_SESSIONS; i++) remaining[i] <= pkts_mem[i];
            busy  <= 1'b1;
            state <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (grant_valid) begin
            cur             <= grant_idx;
            m_udp_hdr_data  <= {grant_len, hdr_mem[grant_idx]};
            m_udp_hdr_valid <= 1'b1;
            state           <= ST_HDR;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_HDR: begin
          if (m_udp_hdr_ready) begin
            m_udp_hdr_valid           <= 1'b0;
            m_udp_payload_axis_tdata  <= gbn_beat(sid_mem[cur], seq_ext);
            m_udp_payload_axis_tvalid <= 1'b1;
            m_udp_payload_axis_tlast  <= (cur_beats == '0);
            state                     <= ST_GBN;
          end
        end
        ST_GBN: begin
          if (m_udp_payload_axis_tready && !m_udp_payload_axis_tlast) begin
            beats_left <= cur_beats;
            if (mode_mem[cur]) m_udp_payload_axis_tdata <= '0;
            else m_udp_payload_axis_tdata <= (cur_beats == BEAT_WIDTH'(1)) ? FILL_LAST : FILL_BODY;
            m_udp_payload_axis_tlast <= (cur_beats == BEAT_WIDTH'(1));
            state                    <= ST_PLD;
          end
        end
        ST_PLD: begin
          if (m_udp_payload_axis_tready && !m_udp_payload_axis_tlast) begin
            beats_left <= next_left;
            if (mode_mem[cur]) m_udp_payload_axis_tdata <= 64'(next_idx);
            else m_udp_payload_axis_tdata <= (next_left == BEAT_WIDTH'(1)) ? FILL_LAST : FILL_BODY;
            m_udp_payload_axis_tlast <= (next_left == BEAT_WIDTH'(1));
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (pkt_close) begin
        seq_mem[cur]              <= seq_mem[cur] + SEQ_WIDTH'(1);
        remaining[cur]            <= remaining[cur] - CNT_WIDTH'(1);
        m_udp_payload_axis_tvalid <= 1'b0;
        m_udp_payload_axis_tlast  <= 1'b0;
        state                     <= ST_ARB;
      end
    end
  end

endmodule

// File: tb/tb_relnet_pktgen.sv
// tb_relnet_pktgen
// Directed bench for relnet_pktgen (SEQ_WIDTH=4 so sequence wrap is short).
// A negedge monitor collects accepted headers and beats into queues and
// checks hold-while-stalled; each test then compares the queues against
// hand-built expected packets.
module tb_relnet_pktgen;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_wr;
  logic [1:0]   cfg_idx;
  logic [111:0] cfg_hdr;
  logic [23:0]  cfg_session_id;
  logic [3:0]   cfg_seq_init;
  logic [15:0]  cfg_pkts;
  logic [7:0]   cfg_beats;
  logic         cfg_mode;
  logic         start;
  logic         busy, done;
  logic [111:0] hdr_data;
  logic         hdr_valid, hdr_ready;
  logic [63:0]  tdata;
  logic [7:0]   tkeep;
  logic         tvalid, tready, tlast, tuser;

  relnet_pktgen #(
    .NUM_SESSIONS (4),
    .SEQ_WIDTH    (4),
    .BEAT_WIDTH   (8),
    .CNT_WIDTH    (16)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .cfg_wr                    (cfg_wr),
    .cfg_idx                   (cfg_idx),
    .cfg_hdr                   (cfg_hdr),
    .cfg_session_id            (cfg_session_id),
    .cfg_seq_init              (cfg_seq_init),
    .cfg_pkts                  (cfg_pkts),
    .cfg_beats                 (cfg_beats),
    .cfg_mode                  (cfg_mode),
    .start                     (start),
    .busy                      (busy),
    .done                      (done),
    .m_udp_hdr_data            (hdr_data),
    .m_udp_hdr_valid           (hdr_valid),
    .m_udp_hdr_ready           (hdr_ready),
    .m_udp_payload_axis_tdata  (tdata),
    .m_udp_payload_axis_tkeep  (tkeep),
    .m_udp_payload_axis_tvalid (tvalid),
    .m_udp_payload_axis_tready (tready),
    .m_udp_payload_axis_tlast  (tlast),
    .m_udp_payload_axis_tuser  (tuser)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int done_cnt = 0;
  bit bp = 1'b0;

  logic [111:0] hdr_q[$];
  logic [64:0]  beat_q[$];

  bit           hs_stall = 1'b0, ps_stall = 1'b0;
  logic [111:0] hs_d;
  logic [64:0]  ps_d;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (bp) begin
      tready    = 1'($urandom_range(0, 1));
      hdr_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hs_stall = 1'b0;
      ps_stall = 1'b0;
    end else begin
      if (hs_stall) begin
        chk("hdr_hold_valid", hdr_valid, 1'b1);
        chk("hdr_hold_data", hdr_data, hs_d);
      end
      if (ps_stall) begin
        chk("pld_hold_valid", tvalid, 1'b1);
        chk("pld_hold_data", {tlast, tdata}, ps_d);
      end
      if (hdr_valid || tvalid) chk("hdr_pld_overlap", hdr_valid & tvalid, 1'b0);
      if (hdr_valid && hdr_ready) hdr_q.push_back(hdr_data);
      if (tvalid && tready) beat_q.push_back({tlast, tdata});
      if (done) done_cnt++;
      hs_stall = hdr_valid && !hdr_ready;
      hs_d     = hdr_data;
      ps_stall = tvalid && !tready;
      ps_d     = {tlast, tdata};
    end
  end

  function automatic logic [23:0] mk_sid(input int src, input int dst);
    return {10'(src), 10'(dst), 4'd0};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hdr_q.delete();
    beat_q.delete();
  endtask

  task automatic cfg(input int idx, input logic [111:0] h, input logic [23:0] sid,
                     input logic [3:0] seq, input logic [15:0] pkts,
                     input logic [7:0] beats, input bit mode);
    cfg_idx        = 2'(idx);
    cfg_hdr        = h;
    cfg_session_id = sid;
    cfg_seq_init   = seq;
    cfg_pkts       = pkts;
    cfg_beats      = beats;
    cfg_mode       = mode;
    cfg_wr         = 1'b1;
    @(posedge clk);
    #1 cfg_wr = 1'b0;
  endtask

  // Pulse start, optionally check start-to-header latency or write config
  // while busy, wait (bounded) for done, then try a start during done.
  task automatic run(input bit lat, input bit poke);
    int cyc;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (lat) begin
      @(negedge clk);
      chk("busy_after_start", busy, 1'b1);
      chk("hdr_valid_cycle1", hdr_valid, 1'b0);
      @(negedge clk);
      chk("hdr_valid_cycle2", hdr_valid, 1'b1);
    end
    if (poke) cfg(0, 112'h0, 24'h0, 4'd0, 16'd1, 8'd0, 1'b0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_within_budget", cyc < 3000, 1'b1);
    chk("busy_low_at_done", busy, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_during_done_ignored", busy, 1'b0);
  endtask

  task automatic check_pkt(input string tag, input logic [111:0] h, input logic [23:0] sid,
                           input logic [31:0] seq, input int nb, input bit mode);
    logic [111:0] eh, gh;
    logic [64:0]  eb, gb;
    eh = h;
    eh[111:96] = 16'(8 * (nb + 1));
    chk({tag, "_hdr_present"}, hdr_q.size() > 0, 1'b1);
    if (hdr_q.size() > 0) begin
      gh = hdr_q.pop_front();
      chk({tag, "_hdr"}, gh, eh);
    end
    for (int i = -1; i < nb; i++) begin
      if (i < 0) eb = {nb == 0, sid, seq, 8'h03};
      else if (mode) eb = {i == nb - 1, 64'(i)};
      else eb = {i == nb - 1, (i == nb - 1) ? 64'h0101010101010101 : 64'h0f0f0f0f0f0f0f0f};
      chk($sformatf("%s_beat%0d_present", tag, i), beat_q.size() > 0, 1'b1);
      if (beat_q.size() > 0) begin
        gb = beat_q.pop_front();
        chk($sformatf("%s_beat%0d", tag, i), gb, eb);
      end
    end
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_hdr_q_empty"}, hdr_q.size(), 0);
    chk({tag, "_beat_q_empty"}, beat_q.size(), 0);
  endtask

  localparam logic [111:0] H0 = {16'hbeef, 16'd5000, 16'd4000, 32'h0a00_0002, 32'h0a00_0001};
  localparam logic [111:0] H1 = {16'h0000, 16'd6001, 16'd6002, 32'hc0a8_0102, 32'hc0a8_0101};
  localparam logic [111:0] H2 = {16'h1234, 16'd80,   16'd81,   32'h0101_0101, 32'h0202_0202};
  localparam logic [111:0] H3 = {16'hffff, 16'd7,    16'd8,    32'h7f00_0001, 32'h7f00_0002};

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] wrap_seq [4];
    rst = 1'b1; start = 1'b0; cfg_wr = 1'b0; cfg_idx = '0; cfg_hdr = '0;
    cfg_session_id = '0; cfg_seq_init = '0; cfg_pkts = '0; cfg_beats = '0;
    cfg_mode = 1'b0; hdr_ready = 1'b1; tready = 1'b1;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hdr_valid", hdr_valid, 1'b0);
    chk("rst_hdr_data", hdr_data, 112'h0);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 64'h0);
    chk("rst_tkeep", tkeep, 8'hff);
    chk("rst_tuser", tuser, 1'b0);

    // single session, 15 packets, 4 payload beats, constant fill
    cfg(0, H0, mk_sid(5, 9), 4'd1, 16'd15, 8'd4, 1'b0);
    done_cnt = 0;
    run(1'b1, 1'b0);
    for (int k = 1; k <= 15; k++)
      check_pkt($sformatf("t1_p%0d", k), H0, mk_sid(5, 9), 32'(k), 4, 1'b0);
    check_drained("t1");
    chk("t1_done_count", done_cnt, 1);

    // two sessions alternate, seq persists across start, cfg_wr while busy dropped
    do_reset();
    cfg(0, H0, mk_sid(1, 2), 4'd3, 16'd3, 8'd1, 1'b1);
    cfg(1, H1, mk_sid(3, 4), 4'd9, 16'd3, 8'd1, 1'b1);
    run(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check_pkt($sformatf("t2_s0_p%0d", k), H0, mk_sid(1, 2), 32'(3 + k), 1, 1'b1);
      check_pkt($sformatf("t2_s1_p%0d", k), H1, mk_sid(3, 4), 32'(9 + k), 1, 1'b1);
    end
    check_drained("t2");
    run(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check_pkt($sformatf("t2b_s0_p%0d", k), H0, mk_sid(1, 2), 32'(6 + k), 1, 1'b1);
      check_pkt($sformatf("t2b_s1_p%0d", k), H1, mk_sid(3, 4), 32'(12 + k), 1, 1'b1);
    end
    check_drained("t2b");

    // seq wrap (14,15,0,1) interleaved with a zero-payload session
    do_reset();
    cfg(1, H1, mk_sid(7, 8), 4'd5, 16'd2, 8'd0, 1'b0);
    cfg(2, H2, mk_sid(10, 11), 4'd14, 16'd4, 8'd2, 1'b0);
    run(1'b0, 1'b0);
    wrap_seq[0] = 4'd14; wrap_seq[1] = 4'd15; wrap_seq[2] = 4'd0; wrap_seq[3] = 4'd1;
    check_pkt("t3_s1_p0", H1, mk_sid(7, 8), 32'd5, 0, 1'b0);
    check_pkt("t3_s2_p0", H2, mk_sid(10, 11), 32'(wrap_seq[0]), 2, 1'b0);
    check_pkt("t3_s1_p1", H1, mk_sid(7, 8), 32'd6, 0, 1'b0);
    for (int k = 1; k < 4; k++)
      check_pkt($sformatf("t3_s2_p%0d", k), H2, mk_sid(10, 11), 32'(wrap_seq[k]), 2, 1'b0);
    check_drained("t3");

    // random backpressure, counting payload of 20 beats
    do_reset();
    cfg(3, H3, mk_sid(1023, 512), 4'd7, 16'd2, 8'd20, 1'b1);
    bp = 1'b1;
    run(1'b0, 1'b0);
    bp = 1'b0;
    @(posedge clk);
    #2 tready = 1'b1; hdr_ready = 1'b1;
    check_pkt("t4_p0", H3, mk_sid(1023, 512), 32'd7, 20, 1'b1);
    check_pkt("t4_p1", H3, mk_sid(1023, 512), 32'd8, 20, 1'b1);
    check_drained("t4");

    // reset mid-payload, then start with cleared config
    do_reset();
    cfg(0, H0, mk_sid(2, 3), 4'd2, 16'd1, 8'd20, 1'b0);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (beat_q.size() < 3 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk("t5_reached_pld", cyc < 100, 1'b1);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_tvalid", tvalid, 1'b0);
    chk("t5_rst_hdr_valid", hdr_valid, 1'b0);
    chk("t5_rst_tlast", tlast, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    #1 rst = 1'b0;
    hdr_q.delete();
    beat_q.delete();
    done_cnt = 0;
    run(1'b0, 1'b0);
    check_drained("t5");
    chk("t5_done_count", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
